// File: rtl/lcd_nibble_writer.sv
// HD44780-style 4-bit LCD writer: power-up wait, nibble init, configuration
// bytes, then a ready/valid byte port that drives each byte as two E strobes.
module lcd_nibble_writer #(
    parameter int T_PWR  = 750000,
    parameter int T_SU   = 2,
    parameter int T_EH   = 12,
    parameter int T_GAP  = 50,
    parameter int T_CMD  = 2000,
    parameter int T_CLR  = 82000,
    parameter int T_INIT = 205000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] iData,
    input  logic       iRS,
    input  logic       iValid,
    output logic       oReady,
    output logic       oInitDone,
    output logic       oLCD_E,
    output logic       oLCD_RS,
    output logic       oLCD_RW,
    output logic [3:0] oLCD_Data
);

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int T_MAX = imax(imax(imax(T_PWR, T_SU), imax(T_EH, T_GAP)),
                                imax(imax(T_CMD, T_CLR), T_INIT));
    localparam int CW    = $clog2(T_MAX + 1);

    localparam logic [3:0] PWRUP     = 4'd0;
    localparam logic [3:0] INIT      = 4'd1;
    localparam logic [3:0] CONFIG    = 4'd2;
    localparam logic [3:0] IDLE      = 4'd3;
    localparam logic [3:0] SETUP_HI  = 4'd4;
    localparam logic [3:0] STROBE_HI = 4'd5;
    localparam logic [3:0] GAP       = 4'd6;
    localparam logic [3:0] SETUP_LO  = 4'd7;
    localparam logic [3:0] STROBE_LO = 4'd8;
    localparam logic [3:0] WAIT      = 4'd9;

    // Sub-phases of one init nibble inside INIT
    localparam logic [1:0] PH_SU = 2'd0;
    localparam logic [1:0] PH_EH = 2'd1;
    localparam logic [1:0] PH_WT = 2'd2;

    // Counter preload so that a phase lasts exactly t clocks
    function automatic logic [CW-1:0] ld(input int t);
        return CW'(t - 1);
    endfunction

    function automatic logic [7:0] cfg_byte(input logic [1:0] i);
        case (i)
            2'd0:    cfg_byte = 8'h28;  // 4-bit bus, 2 lines, 5x8 font
            2'd1:    cfg_byte = 8'h06;  // entry mode: increment, no shift
            2'd2:    cfg_byte = 8'h0C;  // display on, cursor off
            default: cfg_byte = 8'h01;  // clear display
        endcase
    endfunction

    // Clear (0x01) and home (0x02) commands need the long settle time
    function automatic logic is_long(input logic [7:0] b, input logic rs);
        return !rs && ((b == 8'h01) || (b == 8'h02));
    endfunction

    logic [3:0]    state_q, state_n;
    logic [CW-1:0] cnt_q,   cnt_n;
    logic [1:0]    phase_q, phase_n;
    logic [1:0]    idx_q,   idx_n;    // init nibble index, then config byte index
    logic [7:0]    byte_q,  byte_n;
    logic          rs_q,    rs_n;
    logic          done_q,  done_n;

    logic          e_n, lrs_n, ready_n;
    logic [3:0]    data_n;

    // Next-state logic: every timed phase counts down from its preload
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        phase_n = phase_q;
        idx_n   = idx_q;
        byte_n  = byte_q;
        rs_n    = rs_q;
        done_n  = done_q;
        case (state_q)
            PWRUP: begin
                // Counts up so the reset value of zero starts the full wait
                if (cnt_q == ld(T_PWR)) begin
                    state_n = INIT;
                    phase_n = PH_SU;
                    idx_n   = 2'd0;
                    cnt_n   = ld(T_SU);
                end else begin
                    cnt_n = cnt_q + CW'(1);
                end
            end
            CONFIG: begin
                byte_n  = cfg_byte(idx_q);
                rs_n    = 1'b0;
                state_n = SETUP_HI;
                cnt_n   = ld(T_SU);
            end
            IDLE: begin
                if (done_q && iValid) begin
                    byte_n  = iData;
                    rs_n    = iRS;
                    state_n = SETUP_HI;
                    cnt_n   = ld(T_SU);
                end
            end
            INIT, SETUP_HI, STROBE_HI, GAP, SETUP_LO, STROBE_LO, WAIT: begin
                if (cnt_q != '0) begin
                    cnt_n = cnt_q - CW'(1);
                end else begin
                    case (state_q)
                        INIT: begin
                            if (phase_q == PH_SU) begin
                                phase_n = PH_EH;
                                cnt_n   = ld(T_EH);
                            end else if (phase_q == PH_EH) begin
                                phase_n = PH_WT;
                                cnt_n   = ld(T_INIT);
                            end else if (idx_q == 2'd3) begin
                                state_n = CONFIG;
                                idx_n   = 2'd0;
                            end else begin
                                idx_n   = idx_q + 2'd1;
                                phase_n = PH_SU;
                                cnt_n   = ld(T_SU);
                            end
                        end
                        SETUP_HI: begin
                            state_n = STROBE_HI;
                            cnt_n   = ld(T_EH);
                        end
                        STROBE_HI: begin
                            state_n = GAP;
                            cnt_n   = ld(T_GAP);
                        end
                        GAP: begin
                            state_n = SETUP_LO;
                            cnt_n   = ld(T_SU);
                        end
                        SETUP_LO: begin
                            state_n = STROBE_LO;
                            cnt_n   = ld(T_EH);
                        end
                        STROBE_LO: begin
                            state_n = WAIT;
                            cnt_n   = is_long(byte_q, rs_q) ? ld(T_CLR) : ld(T_CMD);
                        end
                        default: begin
                            // End of WAIT: user bytes go idle, config bytes advance
                            if (done_q) begin
                                state_n = IDLE;
                            end else if (idx_q == 2'd3) begin
                                done_n  = 1'b1;
                                state_n = IDLE;
                            end else begin
                                idx_n   = idx_q + 2'd1;
                                state_n = CONFIG;
                            end
                        end
                    endcase
                end
            end
            default: begin
                state_n = PWRUP;
                cnt_n   = '0;
            end
        endcase
    end

    // Pin values decoded from the next state so the LCD pins come straight off flops
    always_comb begin
        e_n    = (state_n == STROBE_HI) || (state_n == STROBE_LO) ||
                 ((state_n == INIT) && (phase_n == PH_EH));
        lrs_n  = 1'b0;
        data_n = 4'h0;
        case (state_n)
            INIT: data_n = (idx_n == 2'd3) ? 4'h2 : 4'h3;
            SETUP_HI, STROBE_HI, GAP: begin
                data_n = byte_n[7:4];
                lrs_n  = rs_n;
            end
            SETUP_LO, STROBE_LO, WAIT: begin
                data_n = byte_n[3:0];
                lrs_n  = rs_n;
            end
            default: ;
        endcase
        ready_n = (state_n == IDLE) && done_n;
    end

    // State, counters, latched byte and output pins
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= PWRUP;
            cnt_q     <= '0;
            phase_q   <= PH_SU;
            idx_q     <= 2'd0;
            byte_q    <= 8'h00;
            rs_q      <= 1'b0;
            done_q    <= 1'b0;
            oLCD_E    <= 1'b0;
            oLCD_RS   <= 1'b0;
            oLCD_Data <= 4'h0;
            oReady    <= 1'b0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            phase_q   <= phase_n;
            idx_q     <= idx_n;
            byte_q    <= byte_n;
            rs_q      <= rs_n;
            done_q    <= done_n;
            oLCD_E    <= e_n;
            oLCD_RS   <= lrs_n;
            oLCD_Data <= data_n;
            oReady    <= ready_n;
        end
    end

    assign oInitDone = done_q;
    assign oLCD_RW   = 1'b0;

endmodule
